// File: rtl/mem_stage_pkg.sv
// Shared encodings and types for the MEM pipeline stage: PC-select codes,
// access FSM states and the default dmem acknowledge timeout.
package mem_stage_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: issues requests, counts wait cycles, stalls the
// pipeline and aborts on timeout. Optional feature macro: MEM_ALIGN_CHECK_EN.
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ack,
  output logic              req,
  output logic              we,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  fsm_state_t        state_r;
  fsm_state_t        state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              access_s;
  logic              misalign_s;
  logic              issue_s;
  logic              abort_s;
  logic [DATA_W-1:0] addr_s;

  // Gating with rst_n drops the request the moment reset asserts, even mid-WAIT.
  assign access_s = (mem_read | mem_write) & rst_n;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = access_s & (addr[1:0] != 2'b00);
  assign addr_s     = addr;
`else
  assign misalign_s = 1'b0;
  assign addr_s     = addr & {{(DATA_W-2){1'b1}}, 2'b00};
`endif

  assign issue_s = access_s & ~misalign_s;
  assign abort_s = (state_r == WAIT) & issue_s & ~ack
                 & (cnt_r == CNT_W'(TIMEOUT - 1));

  // State and wait-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (issue_s && !ack) begin
          state_next_s = WAIT;
          cnt_next_s   = CNT_W'(1'b1);
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end
      end
      WAIT: begin
        if (!issue_s || ack || abort_s) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end else begin
          state_next_s = WAIT;
          cnt_next_s   = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Request, stall and error outputs; request fields follow the frozen EX/MEM register
  always_comb begin
    req       = 1'b0;
    we        = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    stall     = 1'b0;
    err       = 1'b0;
    if (issue_s && !abort_s) begin
      req       = 1'b1;
      we        = mem_write;
      req_addr  = addr_s;
      req_wdata = wdata;
      stall     = ~ack;
    end else begin
      err = abort_s | misalign_s;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory access with stall/abort, branch/jump redirect
// and the MEM/WB register. Optional feature macro: MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_ctrl_reg_write,
  input  logic              ex_mem_ctrl_mem_to_reg,
  input  logic              ex_mem_ctrl_mem_read,
  input  logic              ex_mem_ctrl_mem_write,
  input  logic              ex_mem_ctrl_branch,
  input  logic              ex_mem_ctrl_jump,
  input  logic [DATA_W-1:0] ex_mem_alu_out,
  input  logic [DATA_W-1:0] ex_mem_reg_b_data,
  input  logic [REG_W-1:0]  ex_mem_write_reg_dst,
  input  logic              ex_mem_alu_zero,
  input  logic [DATA_W-1:0] ex_mem_pc_branch,
  input  logic [DATA_W-1:0] ex_mem_pc_jump,
  mem_access_stage_if.master mem,
  output logic [1:0]        pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush_ex,
  output logic              stall_mem,
  output logic              mem_err,
  output logic              mem_wb_ctrl_reg_write,
  output logic              mem_wb_ctrl_mem_to_reg,
  output logic [DATA_W-1:0] mem_wb_alu_out,
  output logic [DATA_W-1:0] mem_wb_mem_data,
  output logic [DATA_W-1:0] mem_wb_data,
  output logic [REG_W-1:0]  mem_wb_rd
);

  logic              bubble_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] wb_data_s;

  dmem_access_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (ex_mem_ctrl_mem_read),
    .mem_write (ex_mem_ctrl_mem_write),
    .addr      (ex_mem_alu_out),
    .wdata     (ex_mem_reg_b_data),
    .ack       (mem.dmem_ack),
    .req       (mem.dmem_req),
    .we        (mem.dmem_we),
    .req_addr  (mem.dmem_addr),
    .req_wdata (mem.dmem_wdata),
    .stall     (stall_mem),
    .err       (mem_err)
  );

  // Redirect selection: jump outranks a taken branch
  always_comb begin
    pc_src    = PC_SEQ;
    pc_target = '0;
    if (ex_mem_ctrl_jump) begin
      pc_src    = PC_JUMP;
      pc_target = ex_mem_pc_jump;
    end else if (ex_mem_ctrl_branch && ex_mem_alu_zero) begin
      pc_src    = PC_BRANCH;
      pc_target = ex_mem_pc_branch;
    end else begin
      pc_src    = PC_SEQ;
      pc_target = '0;
    end
  end

  assign flush_ex = (pc_src != PC_SEQ);

  // An aborted or rejected access drives mem_err and must not reach writeback.
  assign bubble_s    = stall_mem | mem_err;
  assign load_data_s = (ex_mem_ctrl_mem_read && mem.dmem_ack) ? mem.dmem_rdata : '0;
  assign wb_data_s   = ex_mem_ctrl_mem_to_reg ? mem.dmem_rdata : ex_mem_alu_out;

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_ctrl_reg_write  <= 1'b0;
      mem_wb_ctrl_mem_to_reg <= 1'b0;
      mem_wb_alu_out         <= '0;
      mem_wb_mem_data        <= '0;
      mem_wb_data            <= '0;
      mem_wb_rd              <= '0;
    end else if (bubble_s) begin
      mem_wb_ctrl_reg_write  <= 1'b0;
      mem_wb_ctrl_mem_to_reg <= 1'b0;
      mem_wb_alu_out         <= '0;
      mem_wb_mem_data        <= '0;
      mem_wb_data            <= '0;
      mem_wb_rd              <= '0;
    end else begin
      mem_wb_ctrl_reg_write  <= ex_mem_ctrl_reg_write;
      mem_wb_ctrl_mem_to_reg <= ex_mem_ctrl_mem_to_reg;
      mem_wb_alu_out         <= ex_mem_alu_out;
      mem_wb_mem_data        <= load_data_s;
      mem_wb_data            <= wb_data_s;
      mem_wb_rd              <= ex_mem_write_reg_dst;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (TIMEOUT=16), with hand
// sequences for wait states, timeout abort and reset during WAIT.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mr, mw, m2r, rw, br, jmp, zero;
  logic [31:0] alu, wdata, pcb, pcj;
  logic [4:0]  rd;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic        flush_ex, stall_mem, mem_err;
  logic        wb_rw, wb_m2r;
  logic [31:0] wb_alu, wb_md, wb_data;
  logic [4:0]  wb_rd;

  int n_pass  = 0;
  int n_total = 0;

  mem_access_stage_if #(.DATA_W(32)) mem ();

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(16)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ex_mem_ctrl_reg_write  (rw),
    .ex_mem_ctrl_mem_to_reg (m2r),
    .ex_mem_ctrl_mem_read   (mr),
    .ex_mem_ctrl_mem_write  (mw),
    .ex_mem_ctrl_branch     (br),
    .ex_mem_ctrl_jump       (jmp),
    .ex_mem_alu_out         (alu),
    .ex_mem_reg_b_data      (wdata),
    .ex_mem_write_reg_dst   (rd),
    .ex_mem_alu_zero        (zero),
    .ex_mem_pc_branch       (pcb),
    .ex_mem_pc_jump         (pcj),
    .mem                    (mem),
    .pc_src                 (pc_src),
    .pc_target              (pc_target),
    .flush_ex               (flush_ex),
    .stall_mem              (stall_mem),
    .mem_err                (mem_err),
    .mem_wb_ctrl_reg_write  (wb_rw),
    .mem_wb_ctrl_mem_to_reg (wb_m2r),
    .mem_wb_alu_out         (wb_alu),
    .mem_wb_mem_data        (wb_md),
    .mem_wb_data            (wb_data),
    .mem_wb_rd              (wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr, mw, m2r, rw, br, jmp, zero;
    logic [31:0] alu, wdata;
    logic [4:0]  rd;
    logic [31:0] pcb, pcj;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_stall, e_err;
    logic [1:0]  e_src;
    logic [31:0] e_tgt;
    logic        e_rw, e_m2r;
    logic [31:0] e_alu, e_md, e_data;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_in(input logic i_mr, input logic i_mw, input logic i_m2r, input logic i_rw,
                        input logic [31:0] i_alu, input logic [31:0] i_wd, input logic [4:0] i_rd,
                        input logic i_ack, input logic [31:0] i_rdata);
    mr = i_mr; mw = i_mw; m2r = i_m2r; rw = i_rw;
    br = 1'b0; jmp = 1'b0; zero = 1'b0; pcb = 32'h0; pcj = 32'h0;
    alu = i_alu; wdata = i_wd; rd = i_rd;
    mem.dmem_ack = i_ack; mem.dmem_rdata = i_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  stall_cnt;
    bit  seen_err;

    //            mr    mw    m2r   rw    br    jmp   zero  alu           wdata         rd    pcb         pcj          ack   rdata
    //            req   we    addr          wdata         stall err   src    tgt           rw    m2r   alu           md            data          rd
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd3, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'h0000_1234, 5'd3};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF,
                1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd7};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 32'h0, 32'h0, 1'b1, 32'h1111_1111,
                1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0200, 5'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h0, 5'd0, 32'h0000_0040, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 32'h0000_0005, 5'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 5'd0, 32'h0000_0040, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 32'h0000_0006, 5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0007, 32'h0, 5'd0, 32'h0000_0040, 32'h0000_0800, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0000_0800, 1'b0, 1'b0, 32'h0000_0007, 32'h0, 32'h0000_0007, 5'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd9, 32'h0, 32'h0, 1'b1, 32'h0000_0055,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0000_0077, 32'h0, 32'h0000_0077, 5'd9};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 5'd4, 32'h0, 32'h0, 1'b1, 32'h1234_5678,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0};
`else
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 5'd4, 32'h0, 32'h0, 1'b1, 32'h1234_5678,
                1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h0000_0102, 32'h1234_5678, 32'h1234_5678, 5'd4};
`endif
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 5'd2, 32'h0, 32'h0000_0900, 1'b1, 32'h0000_ABCD,
                1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0000_0900, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_ABCD, 32'h0000_ABCD, 5'd2};

    // Reset state
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", {31'b0, mem.dmem_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_mem}, 32'h0);
    chk("rst_err", {31'b0, mem_err}, 32'h0);
    chk("rst_pc_src", {30'b0, pc_src}, 32'h0);
    chk("rst_flush", {31'b0, flush_ex}, 32'h0);
    chk("rst_wb_rw", {31'b0, wb_rw}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle vectors
    for (int i = 0; i < 9; i++) begin
      mr = vecs[i].mr; mw = vecs[i].mw; m2r = vecs[i].m2r; rw = vecs[i].rw;
      br = vecs[i].br; jmp = vecs[i].jmp; zero = vecs[i].zero;
      alu = vecs[i].alu; wdata = vecs[i].wdata; rd = vecs[i].rd;
      pcb = vecs[i].pcb; pcj = vecs[i].pcj;
      mem.dmem_ack = vecs[i].ack; mem.dmem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, mem.dmem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_we", i), {31'b0, mem.dmem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_addr", i), mem.dmem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), mem.dmem_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d_stall", i), {31'b0, stall_mem}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_err", i), {31'b0, mem_err}, {31'b0, vecs[i].e_err});
      chk($sformatf("v%0d_pc_src", i), {30'b0, pc_src}, {30'b0, vecs[i].e_src});
      chk($sformatf("v%0d_pc_target", i), pc_target, vecs[i].e_tgt);
      chk($sformatf("v%0d_flush", i), {31'b0, flush_ex}, {31'b0, (vecs[i].e_src != 2'b00)});
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_rw", i), {31'b0, wb_rw}, {31'b0, vecs[i].e_rw});
      chk($sformatf("v%0d_wb_m2r", i), {31'b0, wb_m2r}, {31'b0, vecs[i].e_m2r});
      chk($sformatf("v%0d_wb_alu", i), wb_alu, vecs[i].e_alu);
      chk($sformatf("v%0d_wb_md", i), wb_md, vecs[i].e_md);
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("v%0d_wb_rd", i), {27'b0, wb_rd}, {27'b0, vecs[i].e_rd});
    end

    // Store acknowledged after three wait cycles
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_A5A5, 5'd5, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st_wait%0d_stall", c), {31'b0, stall_mem}, 32'h1);
      chk($sformatf("st_wait%0d_req", c), {31'b0, mem.dmem_req}, 32'h1);
      chk($sformatf("st_wait%0d_addr", c), mem.dmem_addr, 32'h0000_0300);
      chk($sformatf("st_wait%0d_wdata", c), mem.dmem_wdata, 32'h0000_A5A5);
      @(posedge clk); #1;
      chk($sformatf("st_wait%0d_wb_rd", c), {27'b0, wb_rd}, 32'h0);
      chk($sformatf("st_wait%0d_wb_alu", c), wb_alu, 32'h0);
    end
    mem.dmem_ack = 1'b1;
    #1;
    chk("st_ack_stall", {31'b0, stall_mem}, 32'h0);
    @(posedge clk); #1;
    chk("st_ack_wb_alu", wb_alu, 32'h0000_0300);
    chk("st_ack_wb_rd", {27'b0, wb_rd}, 32'h5);
    chk("st_ack_wb_rw", {31'b0, wb_rw}, 32'h0);

    // Load that is never acknowledged: timeout abort
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd6, 1'b0, 32'h0);
    stall_cnt = 0;
    seen_err  = 1'b0;
    for (int c = 0; c < 40 && !seen_err; c++) begin
      #1;
      if (mem_err) begin
        seen_err = 1'b1;
        chk("abort_req", {31'b0, mem.dmem_req}, 32'h0);
        chk("abort_stall", {31'b0, stall_mem}, 32'h0);
      end else if (stall_mem) begin
        stall_cnt++;
      end
      @(posedge clk); #1;
    end
    chk("abort_seen", {31'b0, seen_err}, 32'h1);
    chk("abort_stall_cycles", stall_cnt, 32'd15);
    chk("abort_wb_rw", {31'b0, wb_rw}, 32'h0);
    chk("abort_wb_rd", {27'b0, wb_rd}, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    chk("post_abort_err", {31'b0, mem_err}, 32'h0);
    chk("post_abort_req", {31'b0, mem.dmem_req}, 32'h0);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0408, 32'h0, 5'd8, 1'b1, 32'h0000_BEEF);
    #1;
    chk("post_abort_idle_stall", {31'b0, stall_mem}, 32'h0);
    @(posedge clk); #1;
    chk("post_abort_wb_data", wb_data, 32'h0000_BEEF);

    // Reset asserted while waiting for an acknowledge
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0, 5'd1, 1'b0, 32'h0);
    #1;
    chk("rw_pre_stall", {31'b0, stall_mem}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rw_rst_req", {31'b0, mem.dmem_req}, 32'h0);
    chk("rw_rst_stall", {31'b0, stall_mem}, 32'h0);
    chk("rw_rst_wb_rw", {31'b0, wb_rw}, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 32'h0, 5'd10, 1'b1, 32'h0000_600D);
    #1;
    chk("rw_after_stall", {31'b0, stall_mem}, 32'h0);
    chk("rw_after_req", {31'b0, mem.dmem_req}, 32'h1);
    @(posedge clk); #1;
    chk("rw_after_wb_data", wb_data, 32'h0000_600D);
    chk("rw_after_wb_rd", {27'b0, wb_rd}, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage sitting between the EX/MEM register and writeback. It issues load/store requests to data memory over a req/ack handshake and stalls the pipeline while memory is busy. It also resolves branches and jumps, producing the PC redirect and flush, and owns the MEM/WB pipeline register that feeds writeback and the ALU forwarding unit.

## Interface
Parameters:
- DATA_W, 32, data/address width
- REG_W, 5, register index width
- TIMEOUT, 16, max wait cycles for dmem_ack before abort (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_read, ex_mem_ctrl_mem_write, ex_mem_ctrl_branch, ex_mem_ctrl_jump  in  1 each  control from EX/MEM
- ex_mem_alu_out  in  DATA_W  address / ALU result
- ex_mem_reg_b_data  in  DATA_W  store data
- ex_mem_write_reg_dst  in  REG_W  destination register
- ex_mem_alu_zero  in  1  branch condition
- ex_mem_pc_branch, ex_mem_pc_jump  in  DATA_W  targets
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr, dmem_wdata  out  DATA_W  address, store data
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_rdata  in  DATA_W  load data
- pc_src  out  2  00 seq, 01 branch, 10 jump
- pc_target  out  DATA_W  redirect address
- flush_ex  out  1  flush IF/ID/EX
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_err  out  1  one-cycle pulse on aborted access
- mem_wb_ctrl_reg_write, mem_wb_ctrl_mem_to_reg  out  1 each
- mem_wb_alu_out, mem_wb_mem_data, mem_wb_data  out  DATA_W  ALU result, load data, selected writeback value
- mem_wb_rd  out  REG_W  destination register

## Operation
- access = mem_read | mem_write. FSM states IDLE and WAIT.
- IDLE: if access, drive dmem_req=1, dmem_we=mem_write, dmem_addr=alu_out, dmem_wdata=reg_b_data (all combinational). If ack is received the same cycle, MEM/WB captures and the FSM stays in IDLE. If there is no ack, go to WAIT with cnt=1.
- WAIT: hold req and all request fields stable. On ack, capture and go to IDLE. Otherwise increment cnt. When cnt==TIMEOUT-1 with no ack, abort: drop req, pulse mem_err, write a bubble to MEM/WB, and go to IDLE.
- stall_mem = access & ~dmem_ack & ~abort. It is combinational.
- While stall_mem=1, MEM/WB receives a bubble: reg_write=0, mem_to_reg=0, data fields 0, rd=0.
- Capture values: mem_wb_mem_data=dmem_rdata when a load acks, else 0. mem_wb_data = mem_to_reg ? dmem_rdata : alu_out.
- Redirect: jump has priority, giving pc_src=10 and pc_target=pc_jump. Else branch & alu_zero gives 01 and pc_branch. Else 00 with pc_target=0.
- flush_ex = pc_src≠00. It is combinational in the same cycle.
- Branch and jump never coincide with access; if they do, the redirect still fires and the access proceeds.
- Non-access, non-stalled instructions pass to MEM/WB in one cycle.

## Timing
- Reset: all outputs 0; FSM in IDLE; cnt=0.
- Zero-wait access: 1 cycle from EX/MEM to MEM/WB.
- N-wait access: stall_mem is high for N cycles, and MEM/WB updates on the edge after ack.
- Abort: stall_mem is high for TIMEOUT-1 cycles. In the abort cycle, mem_err=1 and stall_mem=0.
- dmem_ack seen in IDLE without dmem_req is ignored.
- Reset mid-WAIT: req drops immediately and the transaction is discarded.

## Configuration
- MEM_ALIGN_CHECK_EN defined: an access with alu_out[1:0]≠00 is not issued. In that cycle, mem_err pulses, MEM/WB gets a bubble, and there is no stall.
- MEM_ALIGN_CHECK_EN undefined: dmem_addr[1:0] is forced to 00 and the access proceeds normally.

## Structure
- Shared package mem_stage_pkg holds:
  - the pc_src encodings PC_SEQ/PC_BRANCH/PC_JUMP
  - the FSM state type (IDLE, WAIT)
  - the TIMEOUT default
- Sub-module dmem_access_fsm owns the state, the timeout counter, dmem_* generation, stall_mem, abort and mem_err. The top level owns redirect logic and the MEM/WB register.

## Test plan
- Load, alu_out=0x100, ack in the same cycle with rdata=0xDEADBEEF → stall_mem never high. Next cycle: mem_wb_data=0xDEADBEEF, reg_write=1, rd as given.
- Store with ack delayed 3 cycles → stall_mem high 3 cycles; dmem_addr/wdata stable throughout; MEM/WB holds bubbles, then reg_write=0 after ack.
- Load with no ack and TIMEOUT=16 → stall_mem high 15 cycles, then mem_err pulses for 1 cycle, req drops, FSM returns to IDLE.
- branch=1, alu_zero=1, pc_branch=0x40 → pc_src=01, pc_target=0x40, flush_ex=1 in the same cycle. With alu_zero=0 → pc_src=00.
- jump=1 and branch=1 together → pc_src=10, pc_target=pc_jump.
- MEM_ALIGN_CHECK_EN defined, load at 0x102 → dmem_req=0, mem_err=1, no stall. Undefined → dmem_addr=0x100.
